// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller that turns a dual-port RAM into a
// synchronous FIFO. Write data goes straight from the producer into the RAM.
// This block only sequences the RAM ports and tracks occupancy.
//
// Optional feature: define FIFO_ERR_FLAGS_EN to add the sticky overflow and
// underflow flags and their ports.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   clear      synchronous flush; wins over push/pop in the same cycle
//   push/pop   producer/consumer requests
//   wren, wraddress  RAM write port drive
//   rden, rdaddress  RAM read port drive
//   data_valid RAM data_out holds the word popped in the previous cycle
//   full/empty occupancy flags (registered, no path from push/pop)
//   usedw      words stored, 0..mem_depth
//   overflow/underflow  sticky error flags (FIFO_ERR_FLAGS_EN only)
module fifo_ctrl #(
  parameter int unsigned mem_depth = 32,
  localparam int unsigned AW = $clog2(mem_depth)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  output logic          wren,
  output logic [AW-1:0] wraddress,
  output logic          rden,
  output logic [AW-1:0] rdaddress,
  output logic          data_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   usedw
`ifdef FIFO_ERR_FLAGS_EN
 ,output logic          overflow,
  output logic          underflow
`endif
);

  localparam logic [AW:0] DEPTH = (AW+1)'(mem_depth);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;
  logic          pop_ok;
  logic          push_ok;

  // Acceptance: a full FIFO takes a push only alongside a pop; an empty FIFO
  // never pops, so there is no fall-through.
  always_comb begin
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  // RAM port drive; clear and reset suppress both strobes.
  always_comb begin
    wren      = push_ok & ~clear & ~reset;
    rden      = pop_ok & ~clear & ~reset;
    wraddress = wr_ptr;
    rdaddress = rd_ptr;
  end

  // Next occupancy; unchanged when both or neither request is accepted.
  always_comb begin
    count_next = usedw;
    unique case ({push_ok, pop_ok})
      2'b10:   count_next = usedw + (AW+1)'(1);
      2'b01:   count_next = usedw - (AW+1)'(1);
      default: count_next = usedw;
    endcase
  end

  // Pointers, occupancy, flags and read-data-valid tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      usedw      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      data_valid <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      usedw      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      data_valid <= 1'b0;
    end else begin
      // Power-of-two depth: natural overflow of AW bits gives the wrap.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      usedw      <= count_next;
      full       <= (count_next == DEPTH);
      empty      <= (count_next == '0);
      data_valid <= pop_ok;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; cleared only by reset or clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & ~push_ok) overflow  <= 1'b1;
      if (pop & empty)     underflow <= 1'b1;
    end
  end
`else
  // Rejected requests are silently dropped; no error state is kept.
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed, table-driven bench for fifo_ctrl (mem_depth = 32) with a small
// behavioural RAM (registered read, old data on read-during-write).
module tb_fifo_ctrl;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic          push;
  logic          pop;
  logic [15:0]   data_in;
  logic          wren;
  logic [AW-1:0] wraddress;
  logic          rden;
  logic [AW-1:0] rdaddress;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   usedw;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  fifo_ctrl #(.mem_depth(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .push       (push),
    .pop        (pop),
    .wren       (wren),
    .wraddress  (wraddress),
    .rden       (rden),
    .rdaddress  (rdaddress),
    .data_valid (data_valid),
    .full       (full),
    .empty      (empty),
    .usedw      (usedw)
`ifdef FIFO_ERR_FLAGS_EN
   ,.overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  always #5 clock = ~clock;

  // RAM model
  logic [15:0] mem [DEPTH];
  logic [15:0] data_out;
  always @(posedge clock) begin
    if (rden) data_out <= mem[rdaddress];
    if (wren) mem[wraddress] <= data_in;
  end

  typedef struct {
    bit c, p, q;
    int din;
    bit wr;
    int wa;
    bit rd;
    int ra;
    bit dv;
    int dout;
    bit fu, em;
    int uw;
    bit ov, un;
  } vec_t;

  vec_t vq[$];
  bit   e_ov, e_un;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic add(input bit c, p, q, input int din,
                     input bit wr, input int wa, input bit rd, input int ra,
                     input bit dv, input int dout,
                     input bit fu, em, input int uw);
    vec_t v;
    v.c = c; v.p = p; v.q = q; v.din = din;
    v.wr = wr; v.wa = wa; v.rd = rd; v.ra = ra;
    v.dv = dv; v.dout = dout; v.fu = fu; v.em = em; v.uw = uw;
    v.ov = e_ov; v.un = e_un;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, want %0d", nm, k, act, exp);
    end
  endtask

  initial begin
    int d;
    e_ov = 0; e_un = 0;
    // Idle after reset
    add(0,0,0,0, 0,0,0,0, 0,0, 0,1,0);
    add(0,0,0,0, 0,0,0,0, 0,0, 0,1,0);
    // Fill to 32, then a rejected 33rd push
    for (int i = 0; i < 32; i++) add(0,1,0,i, 1,i,0,0, 0,0, 0,i==0,i);
    add(0,1,0,99, 0,0,0,0, 0,0, 1,0,32); e_ov = 1;
    // Drain all 32, then a rejected extra pop
    for (int i = 0; i < 32; i++) add(0,0,1,0, 0,0,1,i, i>0,i-1, i==0,0,32-i);
    add(0,0,0,0, 0,0,0,0, 1,31, 0,1,0);
    add(0,0,1,0, 0,0,0,0, 0,0, 0,1,0); e_un = 1;
    add(0,0,0,0, 0,0,0,0, 0,0, 0,1,0);
    // Wrap: push 20, pop 20, push 20 (wraps at 13th), pop 20
    for (int i = 0; i < 20; i++) add(0,1,0,100+i, 1,i,0,0, 0,0, 0,i==0,i);
    for (int i = 0; i < 20; i++) add(0,0,1,0, 0,20,1,i, i>0,100+i-1, 0,0,20-i);
    add(0,0,0,0, 0,20,0,20, 1,119, 0,1,0);
    for (int i = 0; i < 20; i++) add(0,1,0,200+i, 1,(20+i)%32,0,20, 0,0, 0,i==0,i);
    for (int i = 0; i < 20; i++) add(0,0,1,0, 0,8,1,(20+i)%32, i>0,200+i-1, 0,0,20-i);
    add(0,0,0,0, 0,8,0,8, 1,219, 0,1,0);
    // Fill, then 10 simultaneous push/pop while full, then drain in order
    for (int i = 0; i < 32; i++) add(0,1,0,300+i, 1,(8+i)%32,0,8, 0,0, 0,i==0,i);
    for (int i = 0; i < 10; i++)
      add(0,1,1,400+i, 1,(8+i)%32,1,(8+i)%32, i>0,300+i-1, 1,0,32);
    for (int i = 0; i < 32; i++) begin
      if (i == 0)          d = 309;
      else if (i - 1 < 22) d = 310 + i - 1;
      else                 d = 400 + i - 1 - 22;
      add(0,0,1,0, 0,18,1,(18+i)%32, 1,d, i==0,0,32-i);
    end
    add(0,0,0,0, 0,18,0,18, 1,409, 0,1,0);
    // Empty plus simultaneous push/pop: push wins, pop rejected
    add(0,1,1,500, 1,18,0,18, 0,0, 0,1,0);
    for (int i = 0; i < 6; i++) add(0,1,0,501+i, 1,19+i,0,18, 0,0, 0,0,1+i);
    // Clear at usedw=7 with push high
    add(1,1,0,600, 0,25,0,18, 0,0, 0,0,7);
    e_ov = 0; e_un = 0;
    add(0,1,0,601, 1,0,0,0, 0,0, 0,1,0);
    // Clear with pop high: no read strobe, no data_valid
    add(1,0,1,0, 0,1,0,0, 0,0, 0,0,1);
    add(0,0,0,0, 0,0,0,0, 0,0, 0,1,0);

    // Reset state, with requests held to show the strobes stay low
    reset = 1'b1; clear = 1'b0; push = 1'b1; pop = 1'b1; data_in = '0;
    #1;
    chk("rst_wren", 0, int'(wren), 0);
    chk("rst_rden", 0, int'(rden), 0);
    chk("rst_empty", 0, int'(empty), 1);
    chk("rst_full", 0, int'(full), 0);
    chk("rst_usedw", 0, int'(usedw), 0);
    chk("rst_dv", 0, int'(data_valid), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_ovf", 0, int'(overflow), 0);
    chk("rst_udf", 0, int'(underflow), 0);
`endif
    @(negedge clock);
    reset = 1'b0; push = 1'b0; pop = 1'b0;

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clock);
      clear = vq[k].c; push = vq[k].p; pop = vq[k].q;
      data_in = 16'(vq[k].din);
      #1;
      chk("wren", k, int'(wren), int'(vq[k].wr));
      chk("wraddress", k, int'(wraddress), vq[k].wa);
      chk("rden", k, int'(rden), int'(vq[k].rd));
      chk("rdaddress", k, int'(rdaddress), vq[k].ra);
      chk("data_valid", k, int'(data_valid), int'(vq[k].dv));
      chk("full", k, int'(full), int'(vq[k].fu));
      chk("empty", k, int'(empty), int'(vq[k].em));
      chk("usedw", k, int'(usedw), vq[k].uw);
      if (vq[k].dv) chk("data_out", k, int'(data_out), vq[k].dout);
`ifdef FIFO_ERR_FLAGS_EN
      chk("overflow", k, int'(overflow), int'(vq[k].ov));
      chk("underflow", k, int'(underflow), int'(vq[k].un));
`endif
    end

    // Asynchronous reset mid-stream with a data_valid pending
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      clear = 1'b0; pop = 1'b0; push = 1'b1; data_in = 16'(700 + i);
    end
    @(negedge clock);
    push = 1'b1; pop = 1'b1; data_in = 16'(703);
    @(negedge clock);
    #1;
    chk("mid_dv", 0, int'(data_valid), 1);
    chk("mid_usedw", 0, int'(usedw), 3);
    chk("mid_out", 0, int'(data_out), 700);
    #1 reset = 1'b1;
    #1;
    chk("arst_dv", 0, int'(data_valid), 0);
    chk("arst_usedw", 0, int'(usedw), 0);
    chk("arst_empty", 0, int'(empty), 1);
    chk("arst_full", 0, int'(full), 0);
    chk("arst_wren", 0, int'(wren), 0);
    chk("arst_rden", 0, int'(rden), 0);
    chk("arst_wraddr", 0, int'(wraddress), 0);
    chk("arst_rdaddr", 0, int'(rdaddress), 0);
    @(negedge clock);
    reset = 1'b0; push = 1'b0; pop = 1'b0;
    #1;
    chk("post_usedw", 0, int'(usedw), 0);
    chk("post_dv", 0, int'(data_valid), 0);
    @(negedge clock);
    push = 1'b1; data_in = 16'(800);
    #1;
    chk("post_wren", 0, int'(wren), 1);
    chk("post_wraddr", 0, int'(wraddress), 0);
    @(negedge clock);
    push = 1'b0;
    #1;
    chk("post_usedw1", 0, int'(usedw), 1);
    chk("post_empty", 0, int'(empty), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
